row_window_sequencer: RTL and testbench

Sequences a binary image, delivered as rows of `ROW_W` bits, into the stream of 2×3 pixel blocks consumed by the connected-domain filter. It pairs consecutive rows (r, r+1) and left-shifts both one pixel per accepted output, exposing the top `WIN_W` bits of each row as a 6-bit block. It sits between the row source (line buffer/DMA) and the block-level filter logic. Both sides use valid/ready handshakes.

---
 rtl/row_window_sequencer_if.sv | 33 +++
 rtl/row_window_sequencer.sv | 159 +++++++++++++++
 tb/tb_row_window_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_window_sequencer_if.sv
// Handshake bundle between the row source, the window sequencer and the block consumer.
// Names carry the sequencer's direction (i_ into it, o_ out of it).
interface row_window_sequencer_if #(
  parameter int ROW_W = 512,
  parameter int WIN_W = 3,
  parameter int COL_W = 9
);
  logic                 i_start;
  logic                 i_row_valid;
  logic                 o_row_ready;
  logic [ROW_W-1:0]     i_row_data;
  logic                 o_block_valid;
  logic                 i_block_ready;
  logic [2*WIN_W-1:0]   o_block;
  logic [COL_W-1:0]     o_col;
  logic [COL_W-1:0]     o_row;
  logic                 o_last_col;
  logic                 o_last_block;
  logic                 o_busy;
  logic                 o_done;

  modport slave (
    input  i_start, i_row_valid, i_row_data, i_block_ready,
    output o_row_ready, o_block_valid, o_block, o_col, o_row,
           o_last_col, o_last_block, o_busy, o_done
  );

  modport master (
    output i_start, i_row_valid, i_row_data, i_block_ready,
    input  o_row_ready, o_block_valid, o_block, o_col, o_row,
           o_last_col, o_last_block, o_busy, o_done
  );
endinterface

// File: rtl/row_window_sequencer.sv
// Turns a frame of binary rows into the 2 x WIN_W block stream of the connected-domain filter:
// consecutive rows are paired and shifted left one pixel per accepted block.
module row_window_sequencer #(
  parameter int ROW_W = 512,
  parameter int WIN_W = 3,
  parameter int ROWS  = 512,
  parameter int COL_W = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  row_window_sequencer_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_W - WIN_W);
  localparam logic [COL_W-1:0] LAST_ROW = COL_W'(ROWS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FIRST,
    S_LOAD_NEXT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ROW_W-1:0]   r_upper_sh;
  logic [ROW_W-1:0]   r_lower_sh;
  logic [ROW_W-1:0]   r_lower_hold;
  logic [COL_W-1:0]   r_col;
  logic [COL_W-1:0]   r_row;
  logic               r_row_ready;
  logic               r_block_valid;
  logic               r_last_col;
  logic               r_last_block;
  logic               r_busy;
  logic               r_done;

  logic [COL_W-1:0]   w_col_inc;
  logic [COL_W-1:0]   w_row_inc;
  logic               w_row_fire;
  logic               w_blk_fire;
  logic               w_one_col;
  logic [2*WIN_W-1:0] w_block;

  assign w_col_inc  = r_col + COL_W'(1);
  assign w_row_inc  = r_row + COL_W'(1);
  assign w_row_fire = bus.i_row_valid & r_row_ready;
  assign w_blk_fire = r_block_valid & bus.i_block_ready;
  // A row exactly as wide as the window yields a single column per pair.
  assign w_one_col  = (LAST_COL == '0);

  genvar gi;
  generate
    for (gi = 0; gi < WIN_W; gi++) begin : g_tap
      assign w_block[WIN_W + gi] = r_upper_sh[ROW_W - WIN_W + gi];
      assign w_block[gi]         = r_lower_sh[ROW_W - WIN_W + gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_upper_sh    <= '0;
      r_lower_sh    <= '0;
      r_lower_hold  <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_row_ready   <= 1'b0;
      r_block_valid <= 1'b0;
      r_last_col    <= 1'b0;
      r_last_block  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state      <= S_LOAD_FIRST;
            r_row        <= '0;
            r_col        <= '0;
            r_row_ready  <= 1'b1;
            r_busy       <= 1'b1;
            r_last_col   <= w_one_col;
            r_last_block <= w_one_col && (LAST_ROW == '0);
          end
        end

        S_LOAD_FIRST: begin
          if (w_row_fire) begin
            r_upper_sh <= bus.i_row_data;
            r_state    <= S_LOAD_NEXT;
          end
        end

        S_LOAD_NEXT: begin
          if (w_row_fire) begin
            r_lower_sh    <= bus.i_row_data;
            r_lower_hold  <= bus.i_row_data;
            r_col         <= '0;
            r_last_col    <= w_one_col;
            r_last_block  <= w_one_col && (r_row == LAST_ROW);
            r_row_ready   <= 1'b0;
            r_block_valid <= 1'b1;
            r_state       <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_blk_fire) begin
            if (!r_last_col) begin
              r_upper_sh   <= {r_upper_sh[ROW_W-2:0], 1'b0};
              r_lower_sh   <= {r_lower_sh[ROW_W-2:0], 1'b0};
              r_col        <= w_col_inc;
              r_last_col   <= (w_col_inc == LAST_COL);
              r_last_block <= (w_col_inc == LAST_COL) && (r_row == LAST_ROW);
            end else if (!r_last_block) begin
              // The old lower row becomes the new upper row, unshifted.
              r_upper_sh    <= r_lower_hold;
              r_row         <= w_row_inc;
              r_last_block  <= (w_row_inc == LAST_ROW);
              r_block_valid <= 1'b0;
              r_row_ready   <= 1'b1;
              r_state       <= S_LOAD_NEXT;
            end else begin
              r_block_valid <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state       <= S_IDLE;
          r_row_ready   <= 1'b0;
          r_block_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_row_ready   = r_row_ready;
  assign bus.o_block_valid = r_block_valid;
  assign bus.o_block       = w_block;
  assign bus.o_col         = r_col;
  assign bus.o_row         = r_row;
  assign bus.o_last_col    = r_last_col;
  assign bus.o_last_block  = r_last_block;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;

endmodule

// File: tb/tb_row_window_sequencer.sv
// Directed bench: an 8-pixel x 3-row instance for hand-computed blocks and corner cases,
// plus a 32 x 12 instance streamed with random rows against a shift model.
module tb_row_window_sequencer;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam int NV = 18;
  localparam int MW = 32;
  localparam int MR = 12;
  localparam int MCOLS = MW - 3 + 1;
  localparam int MBLKS = (MR - 1) * MCOLS;

  logic clk;
  logic rst_s;
  logic rst_m;

  int n_asrt;
  int n_fail;

  row_window_sequencer_if #(.ROW_W(8),  .WIN_W(3), .COL_W(4)) bs ();
  row_window_sequencer_if #(.ROW_W(MW), .WIN_W(3), .COL_W(5)) bm ();

  row_window_sequencer #(.ROW_W(8), .WIN_W(3), .ROWS(3), .COL_W(4)) u_small (
    .i_clk   (clk),
    .i_rst_n (rst_s),
    .bus     (bs)
  );

  row_window_sequencer #(.ROW_W(MW), .WIN_W(3), .ROWS(MR), .COL_W(5)) u_med (
    .i_clk   (clk),
    .i_rst_n (rst_m),
    .bus     (bm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic       rv;
    logic [7:0] rd;
    logic       br;
    logic       e_rr;
    logic       e_bv;
    logic [5:0] e_blk;
    logic [3:0] e_col;
    logic [3:0] e_row;
    logic       e_lc;
    logic       e_lb;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t        vecs [NV];
  logic [7:0]  srows [3];
  logic [5:0]  exp_blk [12];
  logic [MW-1:0] mrows [MR];

  function automatic vec_t mk(input logic st, input logic rv, input logic [7:0] rd,
                              input logic br, input logic rr, input logic bv,
                              input logic [5:0] blk, input logic [3:0] col,
                              input logic [3:0] row, input logic lc, input logic lb,
                              input logic bsy, input logic dn);
    vec_t v;
    v.st = st; v.rv = rv; v.rd = rd; v.br = br;
    v.e_rr = rr; v.e_bv = bv; v.e_blk = blk; v.e_col = col; v.e_row = row;
    v.e_lc = lc; v.e_lb = lb; v.e_busy = bsy; v.e_done = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_asrt++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic small_outs_zero(input string nm);
    chk(nm, {bs.o_row_ready, bs.o_block_valid, bs.o_block, bs.o_col, bs.o_row,
             bs.o_last_col, bs.o_last_block, bs.o_busy, bs.o_done}, 64'd0);
  endtask

  // One small frame; optional backpressure at pair 0 col 3, a 7-cycle row gap
  // before the second row, or an asynchronous reset at pair 1 col 2.
  task automatic run_small(input bit bp, input bit gap, input bit do_rst);
    int blk_idx;
    int row_idx;
    int dones;
    int stall_left;
    int gap_left;
    int cyc;
    bit stalled;
    bit gapped;
    bit fin;
    logic [5:0] cap_blk;
    logic [3:0] cap_col;
    logic [3:0] cap_row;
    blk_idx = 0; row_idx = 0; dones = 0; stall_left = 0; gap_left = 0; cyc = 0;
    stalled = 1'b0; gapped = 1'b0; fin = 1'b0;
    cap_blk = '0; cap_col = '0; cap_row = '0;
    bs.i_start = 1'b1;
    tick();
    bs.i_start = 1'b0;
    while (!fin && cyc < 200) begin
      cyc++;
      if (do_rst && bs.o_block_valid && bs.o_row == 4'd1 && bs.o_col == 4'd2) begin
        #2 rst_s = 1'b0;
        #1 small_outs_zero("async_rst_outs");
        bs.i_row_valid   = 1'b0;
        bs.i_block_ready = 1'b0;
        fin = 1'b1;
      end else begin
        if (stall_left > 0) begin
          chk("bp_block", bs.o_block, cap_blk);
          chk("bp_col",   bs.o_col,   cap_col);
          chk("bp_row",   bs.o_row,   cap_row);
          chk("bp_valid", bs.o_block_valid, 1);
          stall_left--;
        end
        if (bp && !stalled && bs.o_block_valid && bs.o_col == 4'd3 && bs.o_row == 4'd0) begin
          cap_blk = bs.o_block; cap_col = bs.o_col; cap_row = bs.o_row;
          stalled = 1'b1;
          stall_left = 5;
        end
        bs.i_block_ready = (stall_left == 0);
        if (gap && !gapped && bs.o_row_ready && row_idx == 1) begin
          gapped = 1'b1;
          gap_left = 7;
        end
        if (gap_left > 0) begin
          bs.i_row_valid = 1'b0;
          chk("gap_block_valid", bs.o_block_valid, 0);
          gap_left--;
        end else begin
          bs.i_row_valid = 1'b1;
          bs.i_row_data  = (row_idx < 3) ? srows[row_idx] : 8'hFF;
        end
        if (bs.o_block_valid) chk("scan_row_ready", bs.o_row_ready, 0);
        if (bs.o_row_ready && bs.i_row_valid) row_idx++;
        if (bs.o_block_valid && bs.i_block_ready) begin
          if (blk_idx < 12) begin
            chk("s_block", bs.o_block, exp_blk[blk_idx]);
            chk("s_col",   bs.o_col,   blk_idx % 6);
            chk("s_row",   bs.o_row,   blk_idx / 6);
            chk("s_last",  {bs.o_last_col, bs.o_last_block},
                {(blk_idx % 6) == 5, blk_idx == 11});
          end
          $display("small blk %0d: row %0d col %0d block %b", blk_idx, bs.o_row, bs.o_col, bs.o_block);
          blk_idx++;
        end
        if (bs.o_done) begin
          dones++;
          chk("done_busy", bs.o_busy, 1);
        end
        if (dones > 0 && !bs.o_busy) fin = 1'b1;
      end
      tick();
    end
    bs.i_row_valid   = 1'b0;
    bs.i_block_ready = 1'b0;
    chk("small_frame_end", fin, 1);
    if (!do_rst) begin
      chk("small_blk_count",  blk_idx, 12);
      chk("small_done_count", dones,   1);
      chk("small_rows_used",  row_idx, 3);
    end
  endtask

  task automatic run_medium();
    int k;
    int ri;
    int dones;
    int cyc;
    int p;
    int c;
    bit fin;
    bit sent_start;
    logic [MW-1:0] up;
    logic [MW-1:0] lo;
    logic [5:0] eb;
    k = 0; ri = 0; dones = 0; cyc = 0; p = 0; c = 0;
    fin = 1'b0; sent_start = 1'b0;
    for (int i = 0; i < MR; i++) mrows[i] = $urandom;
    bm.i_start = 1'b1;
    tick();
    bm.i_start = 1'b0;
    while (!fin && cyc < 4000) begin
      cyc++;
      bm.i_start = (k == 5 && !sent_start);
      if (k == 5) sent_start = 1'b1;
      bm.i_row_valid   = 1'b1;
      bm.i_row_data    = (ri < MR) ? mrows[ri] : '1;
      bm.i_block_ready = ($urandom_range(0, 3) != 0);
      if (bm.o_row_ready && bm.i_row_valid) ri++;
      if (bm.o_block_valid && bm.i_block_ready) begin
        if (k < MBLKS) begin
          p  = k / MCOLS;
          c  = k % MCOLS;
          up = mrows[p] << c;
          lo = mrows[p + 1] << c;
          eb = {up[MW-1 -: 3], lo[MW-1 -: 3]};
          chk("m_block", bm.o_block, eb);
          chk("m_colrow", {bm.o_col, bm.o_row}, {5'(c), 5'(p)});
          chk("m_last", {bm.o_last_col, bm.o_last_block},
              {c == MCOLS - 1, (c == MCOLS - 1) && (p == MR - 2)});
        end
        $display("med blk %0d: row %0d col %0d block %b", k, bm.o_row, bm.o_col, bm.o_block);
        k++;
      end
      if (bm.o_done) begin
        dones++;
        chk("m_done_busy", bm.o_busy, 1);
      end
      if (dones > 0 && !bm.o_busy) fin = 1'b1;
      tick();
    end
    bm.i_start = 1'b0;
    bm.i_row_valid = 1'b0;
    bm.i_block_ready = 1'b0;
    chk("med_frame_end",  fin,   1);
    chk("med_blk_count",  k,     MBLKS);
    chk("med_done_count", dones, 1);
    chk("med_rows_used",  ri,    MR);
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    srows[0] = 8'hA0;
    srows[1] = 8'hE1;
    srows[2] = 8'h07;
    exp_blk[0]  = 6'b101111; exp_blk[1]  = 6'b010110; exp_blk[2]  = 6'b100100;
    exp_blk[3]  = 6'b000000; exp_blk[4]  = 6'b000000; exp_blk[5]  = 6'b000001;
    exp_blk[6]  = 6'b111000; exp_blk[7]  = 6'b110000; exp_blk[8]  = 6'b100000;
    exp_blk[9]  = 6'b000001; exp_blk[10] = 6'b000011; exp_blk[11] = 6'b001111;

    //             st rv rd     br  rr bv blk        col   row   lc lb busy done
    vecs[0]  = mk(H, L, 8'h00, L,  H, L, 6'd0,      4'd0, 4'd0, L, L, H, L);
    vecs[1]  = mk(L, H, 8'hA0, L,  H, L, 6'd0,      4'd0, 4'd0, L, L, H, L);
    vecs[2]  = mk(L, H, 8'hE1, L,  L, H, 6'b101111, 4'd0, 4'd0, L, L, H, L);
    vecs[3]  = mk(L, L, 8'h00, H,  L, H, 6'b010110, 4'd1, 4'd0, L, L, H, L);
    vecs[4]  = mk(L, H, 8'hFF, H,  L, H, 6'b100100, 4'd2, 4'd0, L, L, H, L);
    vecs[5]  = mk(L, L, 8'h00, H,  L, H, 6'b000000, 4'd3, 4'd0, L, L, H, L);
    vecs[6]  = mk(L, L, 8'h00, H,  L, H, 6'b000000, 4'd4, 4'd0, L, L, H, L);
    vecs[7]  = mk(L, L, 8'h00, H,  L, H, 6'b000001, 4'd5, 4'd0, H, L, H, L);
    vecs[8]  = mk(L, L, 8'h00, H,  H, L, 6'd0,      4'd0, 4'd0, L, L, H, L);
    vecs[9]  = mk(L, H, 8'h07, L,  L, H, 6'b111000, 4'd0, 4'd1, L, L, H, L);
    vecs[10] = mk(L, L, 8'h00, H,  L, H, 6'b110000, 4'd1, 4'd1, L, L, H, L);
    vecs[11] = mk(L, L, 8'h00, H,  L, H, 6'b100000, 4'd2, 4'd1, L, L, H, L);
    vecs[12] = mk(L, L, 8'h00, H,  L, H, 6'b000001, 4'd3, 4'd1, L, L, H, L);
    vecs[13] = mk(L, L, 8'h00, H,  L, H, 6'b000011, 4'd4, 4'd1, L, L, H, L);
    vecs[14] = mk(L, L, 8'h00, H,  L, H, 6'b001111, 4'd5, 4'd1, H, H, H, L);
    vecs[15] = mk(L, L, 8'h00, H,  L, L, 6'd0,      4'd0, 4'd0, L, L, H, H);
    vecs[16] = mk(L, L, 8'h00, L,  L, L, 6'd0,      4'd0, 4'd0, L, L, L, L);
    vecs[17] = mk(L, L, 8'h00, L,  L, L, 6'd0,      4'd0, 4'd0, L, L, L, L);

    rst_s = 1'b0;
    rst_m = 1'b0;
    bs.i_start = 1'b0; bs.i_row_valid = 1'b0; bs.i_row_data = '0; bs.i_block_ready = 1'b0;
    bm.i_start = 1'b0; bm.i_row_valid = 1'b0; bm.i_row_data = '0; bm.i_block_ready = 1'b0;

    // Reset held with random inputs: everything must read zero.
    for (int i = 0; i < 3; i++) begin
      bs.i_start = 1'($urandom); bs.i_row_valid = 1'($urandom);
      bs.i_row_data = 8'($urandom); bs.i_block_ready = 1'($urandom);
      bm.i_start = 1'($urandom); bm.i_row_valid = 1'($urandom);
      bm.i_row_data = $urandom; bm.i_block_ready = 1'($urandom);
      tick();
      small_outs_zero("rst_small_outs");
      chk("rst_med_outs", {bm.o_row_ready, bm.o_block_valid, bm.o_block, bm.o_col, bm.o_row,
                           bm.o_last_col, bm.o_last_block, bm.o_busy, bm.o_done}, 64'd0);
    end
    bs.i_start = 1'b0; bs.i_row_valid = 1'b0; bs.i_row_data = '0; bs.i_block_ready = 1'b0;
    bm.i_start = 1'b0; bm.i_row_valid = 1'b0; bm.i_row_data = '0; bm.i_block_ready = 1'b0;
    rst_s = 1'b1;
    rst_m = 1'b1;
    tick();

    // Zero-stall small frame, one vector per cycle.
    for (int i = 0; i < NV; i++) begin
      bs.i_start       = vecs[i].st;
      bs.i_row_valid   = vecs[i].rv;
      bs.i_row_data    = vecs[i].rd;
      bs.i_block_ready = vecs[i].br;
      tick();
      chk("v_row_ready",   bs.o_row_ready,   vecs[i].e_rr);
      chk("v_block_valid", bs.o_block_valid, vecs[i].e_bv);
      chk("v_busy",        bs.o_busy,        vecs[i].e_busy);
      chk("v_done",        bs.o_done,        vecs[i].e_done);
      if (vecs[i].e_bv) begin
        chk("v_block", bs.o_block, vecs[i].e_blk);
        chk("v_col",   bs.o_col,   vecs[i].e_col);
        chk("v_row",   bs.o_row,   vecs[i].e_row);
        chk("v_last",  {bs.o_last_col, bs.o_last_block}, {vecs[i].e_lc, vecs[i].e_lb});
      end
      $display("vec %0d: rr %b bv %b block %b col %0d row %0d busy %b done %b",
               i, bs.o_row_ready, bs.o_block_valid, bs.o_block, bs.o_col, bs.o_row,
               bs.o_busy, bs.o_done);
    end
    bs.i_row_valid = 1'b0;
    bs.i_block_ready = 1'b0;

    run_small(1'b1, 1'b1, 1'b0);
    tick();

    run_small(1'b0, 1'b0, 1'b1);
    tick();
    small_outs_zero("rst_hold_outs");
    rst_s = 1'b1;
    tick();
    run_small(1'b0, 1'b0, 1'b0);

    run_medium();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
